// File: rtl/pio_out_pulse.sv
// rtl/pio_out_pulse.sv - Avalon-MM output PIO with set/clear access and a shared one-shot pulse generator
// Optional STATUS register and pulse-done interrupt enabled by macro PIO_OUT_PULSE_IRQ_EN.
module pio_out_pulse #(
    parameter int               WIDTH     = 4,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rd_q, rd_d;

    logic             wr;
    logic [WIDTH-1:0] wmask;
    logic             trig;
    logic             expire;
    logic             unused_wdata;

    assign wr     = chipselect & ~write_n;
    assign wmask  = writedata[WIDTH-1:0];
    assign trig   = wr && (address == 3'd3) && (|wmask) && (|len_q);
    // A reload on the final count cycle suppresses the expiry entirely.
    assign expire = !trig && (cnt_q == CNT_ONE);
    assign unused_wdata = ^writedata;

    assign out_port = data_q | mask_q;
    assign readdata = rd_q;

`ifdef PIO_OUT_PULSE_IRQ_EN
    logic done_q, done_d;
    logic ien_q, ien_d;

    always_comb begin
        done_d = done_q;
        ien_d  = ien_q;
        if (wr && address == 3'd6) begin
            ien_d = writedata[1];
            if (writedata[0]) begin
                done_d = 1'b0;
            end
        end
        // Expiry after the W1C so a coincident clear loses.
        if (expire) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            ien_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            ien_q  <= ien_d;
        end
    end

    assign irq = done_q & ien_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        mask_d = mask_q;
        if (trig) begin
            cnt_d  = len_q;
            mask_d = mask_q | wmask;
        end else if (expire) begin
            cnt_d  = '0;
            mask_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        if (wr) begin
            case (address)
                3'd0:    data_d = wmask;
                3'd2:    len_d  = writedata[CNT_W-1:0];
                3'd4:    data_d = data_q | wmask;
                3'd5:    data_d = data_q & ~wmask;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_d = '0;
        case (address)
            3'd0:    rd_d[WIDTH-1:0] = data_q;
            3'd1:    rd_d[WIDTH-1:0] = out_port;
            3'd2:    rd_d[CNT_W-1:0] = len_q;
            3'd3:    rd_d[WIDTH-1:0] = mask_q;
`ifdef PIO_OUT_PULSE_IRQ_EN
            3'd6:    rd_d[1:0]       = {ien_q, done_q};
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VAL;
            len_q  <= '0;
            mask_q <= '0;
            cnt_q  <= '0;
            rd_q   <= '0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
        end
    end

endmodule

// File: tb/tb_pio_out_pulse.sv
// tb/tb_pio_out_pulse.sv - scoreboard bench for pio_out_pulse with a time-stamped pulse reference model
module tb_pio_out_pulse;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;
    localparam logic [WIDTH-1:0] RST_VAL = '0;
`ifdef PIO_OUT_PULSE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             irq;

    pio_out_pulse #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VAL(RST_VAL)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      rd;
        logic [WIDTH-1:0] out;
        logic             irq;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference state: the pulse is described by the edge number at which it ends.
    logic [WIDTH-1:0] m_data = RST_VAL;
    logic [CNT_W-1:0] m_len  = '0;
    logic [WIDTH-1:0] m_mask = '0;
    int               m_end  = 0;
    bit               m_done = 1'b0;
    bit               m_ien  = 1'b0;
    int               cyc    = 0;

    task automatic model_edge(input logic r, input logic cs, input logic wn,
                              input logic [2:0] a, input logic [31:0] wd);
        exp_t             x;
        int               e;
        logic [WIDTH-1:0] wm;
        bit               wr, trig, expire;
        e    = cyc + 1;
        x.rd = '0;
        case (a)
            3'd0: x.rd = 32'(m_data);
            3'd1: x.rd = 32'(m_data | m_mask);
            3'd2: x.rd = 32'(m_len);
            3'd3: x.rd = 32'(m_mask);
            3'd6: x.rd = IRQ_ON ? {30'd0, m_ien, m_done} : 32'd0;
            default: x.rd = '0;
        endcase
        if (r) begin
            m_data = RST_VAL; m_len = '0; m_mask = '0; m_end = 0;
            m_done = 1'b0; m_ien = 1'b0; x.rd = '0;
        end else begin
            wr     = cs && !wn;
            wm     = wd[WIDTH-1:0];
            trig   = wr && a == 3'd3 && wm != '0 && m_len != '0;
            expire = !trig && m_mask != '0 && e == m_end;
            if (trig) begin
                m_mask = m_mask | wm;
                m_end  = e + int'(m_len);
            end else if (expire) begin
                m_mask = '0;
            end
            if (wr) begin
                case (a)
                    3'd0: m_data = wm;
                    3'd2: m_len  = wd[CNT_W-1:0];
                    3'd4: m_data = m_data | wm;
                    3'd5: m_data = m_data & ~wm;
                    3'd6: if (IRQ_ON) begin
                        m_ien = wd[1];
                        if (wd[0]) m_done = 1'b0;
                    end
                    default: ;
                endcase
            end
            if (expire && IRQ_ON) m_done = 1'b1;
        end
        x.out = m_data | m_mask;
        x.irq = m_done && m_ien;
        exp_q.push_back(x);
        cyc = e;
    endtask

    task automatic step(input logic r, input logic cs, input logic wn,
                        input logic [2:0] a, input logic [31:0] wd);
        @(negedge clk);
        reset = r; chipselect = cs; write_n = wn; address = a; writedata = wd;
        model_edge(r, cs, wn, a, wd);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] wd);
        step(1'b0, 1'b1, 1'b0, a, wd);
    endtask

    task automatic bus_rd(input logic [2:0] a);
        step(1'b0, 1'b0, 1'b1, a, $urandom());
    endtask

    task automatic idle(input int n, input logic [2:0] a);
        for (int i = 0; i < n; i++) bus_rd(a);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                checks += 3;
                if (readdata !== x.rd) begin
                    errors++;
                    $display("FAIL readdata cyc=%0d got %h exp %h", cyc, readdata, x.rd);
                end
                if (out_port !== x.out) begin
                    errors++;
                    $display("FAIL out_port cyc=%0d got %h exp %h", cyc, out_port, x.out);
                end
                if (irq !== x.irq) begin
                    errors++;
                    $display("FAIL irq cyc=%0d got %b exp %b", cyc, irq, x.irq);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] wd;
        logic [2:0]  a;
        step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 3'd1, 32'd0);
        bus_rd(3'd0); bus_rd(3'd1); bus_rd(3'd3);

        bus_wr(3'd0, 32'hFFFF_FFF5);
        bus_wr(3'd4, 32'h2);
        bus_wr(3'd5, 32'h4);
        bus_rd(3'd1); bus_rd(3'd0);

        bus_wr(3'd2, 32'd3);
        bus_wr(3'd3, 32'h8);
        idle(5, 3'd3);

        bus_wr(3'd2, 32'd4);
        bus_wr(3'd3, 32'h1);
        idle(3, 3'd3);
        bus_wr(3'd3, 32'h2);
        idle(6, 3'd3);

        bus_wr(3'd2, 32'd0);
        bus_wr(3'd3, 32'hF);
        idle(2, 3'd1);
        bus_wr(3'd2, 32'd10);
        bus_wr(3'd3, 32'hF);
        idle(4, 3'd3);
        step(1'b1, 1'b0, 1'b1, 3'd3, 32'd0);
        idle(3, 3'd1);

        bus_wr(3'd6, 32'h2);
        bus_wr(3'd2, 32'd2);
        bus_wr(3'd3, 32'h1);
        idle(4, 3'd6);
        bus_wr(3'd6, 32'h3);
        idle(2, 3'd6);
        bus_wr(3'd3, 32'h1);
        bus_rd(3'd6);
        bus_wr(3'd6, 32'h3);
        idle(3, 3'd6);

        for (int i = 0; i < 3000; i++) begin
            a  = 3'($urandom_range(0, 7));
            wd = $urandom();
            if (a == 3'd2) wd[15:0] = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0)
                step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
            else
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a, wd);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
